// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiply,
// feeding the memory-access stage through one registered output slot.
module execute_unit #(
    parameter int MUL_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  opcode,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    input  logic [7:0]  imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [71:0] Address_and_Value,
    output logic        isLoad,
    output logic        isMemWrite,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    localparam int CW = $clog2(MUL_CYCLES + 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_LOAD  = 4'd9;
    localparam logic [3:0] OP_STORE = 4'd10;

    state_t        state;
    state_t        next_state;
    logic [63:0]   mul_a;
    logic [63:0]   mul_b;
    logic [63:0]   acc;
    logic [63:0]   step_acc;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          mul_last;
    logic [63:0]   alu_value;
    logic [7:0]    alu_addr;
    logic          alu_load;
    logic          alu_store;

    assign in_ready = !rst && state == IDLE && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == MUL);
    assign step_acc = mul_b[0] ? acc + mul_a : acc;
    assign mul_last = (state == MUL) && (cnt == CW'(MUL_CYCLES - 1));

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept && opcode == OP_MUL) next_state = MUL;
            MUL:     if (mul_last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        alu_value = '0;
        alu_addr  = '0;
        alu_load  = 1'b0;
        alu_store = 1'b0;
        case (opcode)
            OP_ADD: alu_value = op_a + op_b;
            OP_SUB: alu_value = op_a - op_b;
            OP_AND: alu_value = op_a & op_b;
            OP_OR:  alu_value = op_a | op_b;
            OP_XOR: alu_value = op_a ^ op_b;
            OP_SLL: alu_value = op_a << op_b[5:0];
            OP_SRL: alu_value = op_a >> op_b[5:0];
            OP_SLT: alu_value = {63'd0, $signed(op_a) < $signed(op_b)};
            OP_LOAD: begin
                alu_addr = op_a[7:0] + imm;
                alu_load = 1'b1;
            end
            OP_STORE: begin
                alu_value = op_b;
                alu_addr  = op_a[7:0] + imm;
                alu_store = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a             <= '0;
            mul_b             <= '0;
            acc               <= '0;
            cnt               <= '0;
            out_valid         <= 1'b0;
            Address_and_Value <= '0;
            isLoad            <= 1'b0;
            isMemWrite        <= 1'b0;
        end else begin
            if (accept && opcode == OP_MUL) begin
                mul_a <= op_a;
                mul_b <= op_b;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == MUL) begin
                acc   <= step_acc;
                mul_a <= mul_a << 1;
                mul_b <= mul_b >> 1;
                cnt   <= cnt + 1'b1;
            end
            // A new result always wins the slot; otherwise a consumed slot empties.
            if (accept && opcode != OP_MUL) begin
                Address_and_Value <= {alu_value, alu_addr};
                isLoad            <= alu_load;
                isMemWrite        <= alu_store;
                out_valid         <= 1'b1;
            end else if (mul_last) begin
                Address_and_Value <= {step_acc, 8'h00};
                isLoad            <= 1'b0;
                isMemWrite        <= 1'b0;
                out_valid         <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Directed self-checking bench for execute_unit.
module tb_execute_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [7:0]  imm;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] Address_and_Value;
    logic        isLoad;
    logic        isMemWrite;
    logic        busy;

    int checks;
    int errors;

    execute_unit #(.MUL_CYCLES(64)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .opcode(opcode),
        .op_a(op_a),
        .op_b(op_b),
        .imm(imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Address_and_Value(Address_and_Value),
        .isLoad(isLoad),
        .isMemWrite(isMemWrite),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [7:0] im);
        opcode   = op;
        op_a     = a;
        op_b     = b;
        imm      = im;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (Address_and_Value !== 72'h0) begin
            errors++;
            $display("FAIL reset_bundle got %h want 0", Address_and_Value);
        end
        checks++;
        if ({isLoad, isMemWrite, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {isLoad, isMemWrite, busy});
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(4'd0, 64'd5, 64'd7, 8'h00);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_valid got %b want 1", out_valid);
        end
        checks++;
        if (Address_and_Value !== {64'd12, 8'h00}) begin
            errors++;
            $display("FAIL add_bundle got %h want %h", Address_and_Value, {64'd12, 8'h00});
        end
        checks++;
        if ({isLoad, isMemWrite} !== 2'b00) begin
            errors++;
            $display("FAIL add_flags got %b want 00", {isLoad, isMemWrite});
        end
    endtask

    task automatic test_store_load();
        issue(4'd10, 64'hFE, 64'h1234, 8'h03);
        checks++;
        if (Address_and_Value !== {64'h1234, 8'h01}) begin
            errors++;
            $display("FAIL store_bundle got %h want %h", Address_and_Value, {64'h1234, 8'h01});
        end
        checks++;
        if ({out_valid, isLoad, isMemWrite} !== 3'b101) begin
            errors++;
            $display("FAIL store_flags got %b want 101", {out_valid, isLoad, isMemWrite});
        end
        issue(4'd9, 64'hFE, 64'h1234, 8'h03);
        checks++;
        if (Address_and_Value !== {64'h0, 8'h01}) begin
            errors++;
            $display("FAIL load_bundle got %h want %h", Address_and_Value, {64'h0, 8'h01});
        end
        checks++;
        if ({out_valid, isLoad, isMemWrite} !== 3'b110) begin
            errors++;
            $display("FAIL load_flags got %b want 110", {out_valid, isLoad, isMemWrite});
        end
    endtask

    task automatic test_alu_vectors();
        logic [3:0]  t_op  [0:10];
        logic [63:0] t_a   [0:10];
        logic [63:0] t_b   [0:10];
        logic [7:0]  t_imm [0:10];
        logic [63:0] t_val [0:10];
        t_op[0]  = 4'd1;  t_a[0]  = 64'd3;    t_b[0]  = 64'd5;
        t_imm[0] = 8'h00; t_val[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        t_op[1]  = 4'd2;  t_a[1]  = 64'hF0F0; t_b[1]  = 64'hFF00;
        t_imm[1] = 8'h00; t_val[1] = 64'hF000;
        t_op[2]  = 4'd3;  t_a[2]  = 64'hF0F0; t_b[2]  = 64'h0F0F;
        t_imm[2] = 8'h00; t_val[2] = 64'hFFFF;
        t_op[3]  = 4'd4;  t_a[3]  = 64'hAAAA; t_b[3]  = 64'hFFFF;
        t_imm[3] = 8'h00; t_val[3] = 64'h5555;
        t_op[4]  = 4'd5;  t_a[4]  = 64'd1;    t_b[4]  = 64'h41;
        t_imm[4] = 8'h00; t_val[4] = 64'd2;
        t_op[5]  = 4'd6;  t_a[5]  = 64'h8000_0000_0000_0000;
        t_b[5]   = 64'd63; t_imm[5] = 8'h00; t_val[5] = 64'd1;
        t_op[6]  = 4'd7;  t_a[6]  = 64'hFFFF_FFFF_FFFF_FFFF;
        t_b[6]   = 64'd0; t_imm[6] = 8'h00; t_val[6] = 64'd1;
        t_op[7]  = 4'd7;  t_a[7]  = 64'd0;
        t_b[7]   = 64'hFFFF_FFFF_FFFF_FFFF; t_imm[7] = 8'h00; t_val[7] = 64'd0;
        t_op[8]  = 4'd7;  t_a[8]  = 64'd1;    t_b[8]  = 64'd2;
        t_imm[8] = 8'h00; t_val[8] = 64'd1;
        t_op[9]  = 4'd15; t_a[9]  = 64'd5;    t_b[9]  = 64'd5;
        t_imm[9] = 8'h09; t_val[9] = 64'd0;
        t_op[10] = 4'd0;  t_a[10] = 64'd1;    t_b[10] = 64'd1;
        t_imm[10] = 8'h7F; t_val[10] = 64'd2;
        for (int i = 0; i < 11; i++) begin
            issue(t_op[i], t_a[i], t_b[i], t_imm[i]);
            checks++;
            if ({out_valid, isLoad, isMemWrite, Address_and_Value} !==
                {3'b100, t_val[i], 8'h00}) begin
                errors++;
                $display("FAIL alu_vec%0d got v=%b l=%b w=%b av=%h want v=1 l=0 w=0 av=%h",
                         i, out_valid, isLoad, isMemWrite, Address_and_Value,
                         {t_val[i], 8'h00});
            end
        end
    endtask

    task automatic test_mul();
        int busy_cnt;
        int stall_cnt;
        logic        v64;
        logic [71:0] av64;
        busy_cnt  = 0;
        stall_cnt = 0;
        v64       = 1'b0;
        av64      = '0;
        out_ready = 1'b1;
        issue(4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 8'h00);
        for (int i = 0; i <= 66; i++) begin
            if (i > 0) step();
            if (busy === 1'b1) busy_cnt++;
            if (in_ready === 1'b0) stall_cnt++;
            if (i == 63) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL mul_early_valid got %b want 0", out_valid);
                end
            end
            if (i == 64) begin
                v64  = out_valid;
                av64 = Address_and_Value;
            end
        end
        checks++;
        if (busy_cnt != 64) begin
            errors++;
            $display("FAIL mul_busy_cycles got %0d want 64", busy_cnt);
        end
        checks++;
        if (stall_cnt != 65) begin
            errors++;
            $display("FAIL mul_stall_cycles got %0d want 65", stall_cnt);
        end
        checks++;
        if (v64 !== 1'b1) begin
            errors++;
            $display("FAIL mul_valid got %b want 1", v64);
        end
        checks++;
        if (av64 !== {64'hFFFF_FFFF_FFFF_FFFD, 8'h00}) begin
            errors++;
            $display("FAIL mul_value got %h want %h", av64,
                     {64'hFFFF_FFFF_FFFF_FFFD, 8'h00});
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(4'd1, 64'd10, 64'd3, 8'h00);
        opcode   = 4'd4;
        op_a     = 64'hF0;
        op_b     = 64'hFF;
        imm      = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready, Address_and_Value} !== {2'b10, 64'd7, 8'h00}) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b rdy=%b av=%h want v=1 rdy=0 av=%h",
                         i, out_valid, in_ready, Address_and_Value, {64'd7, 8'h00});
            end
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, Address_and_Value} !== {1'b1, 64'h0F, 8'h00}) begin
            errors++;
            $display("FAIL handover got v=%b av=%h want v=1 av=%h",
                     out_valid, Address_and_Value, {64'h0F, 8'h00});
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  b_op  [0:2];
        logic [63:0] b_a   [0:2];
        logic [63:0] b_b   [0:2];
        logic [63:0] b_val [0:2];
        b_op[0] = 4'd0; b_a[0] = 64'd1; b_b[0] = 64'd2; b_val[0] = 64'd3;
        b_op[1] = 4'd1; b_a[1] = 64'd9; b_b[1] = 64'd4; b_val[1] = 64'd5;
        b_op[2] = 4'd3; b_a[2] = 64'd1; b_b[2] = 64'd2; b_val[2] = 64'd3;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        imm       = 8'h00;
        for (int i = 0; i < 3; i++) begin
            opcode = b_op[i];
            op_a   = b_a[i];
            op_b   = b_b[i];
            step();
            checks++;
            if ({out_valid, Address_and_Value} !== {1'b1, b_val[i], 8'h00}) begin
                errors++;
                $display("FAIL b2b%0d got v=%b av=%h want v=1 av=%h",
                         i, out_valid, Address_and_Value, {b_val[i], 8'h00});
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_mul();
        int stray;
        stray     = 0;
        out_ready = 1'b1;
        issue(4'd8, 64'd3, 64'd5, 8'h00);
        repeat (19) step();
        rst = 1'b1;
        step();
        checks++;
        if ({busy, out_valid, in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL midmul_reset got busy=%b v=%b rdy=%b want 000",
                     busy, out_valid, in_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL midmul_stale got %0d stray cycles want 0", stray);
        end
        issue(4'd0, 64'd1, 64'd2, 8'h00);
        checks++;
        if ({out_valid, Address_and_Value} !== {1'b1, 64'd3, 8'h00}) begin
            errors++;
            $display("FAIL midmul_add got v=%b av=%h want v=1 av=%h",
                     out_valid, Address_and_Value, {64'd3, 8'h00});
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        op_a      = '0;
        op_b      = '0;
        imm       = '0;
        test_reset();
        test_add();
        test_store_load();
        test_alu_vectors();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_unit.md
# execute_unit

Execute stage of the pipelined processor, directly upstream of the memory-access stage. Accepts decoded operands and an opcode and computes ALU results, including an iterative 64-cycle multiply. Produces the 72-bit `{value, address}` bundle plus `isLoad` and `isMemWrite` controls consumed by memory access. Uses a valid/ready handshake on both sides with a single registered output slot.

## Interface
Parameters:
- `MUL_CYCLES`, default 64: multiply iterations, one bit of `op_b` per cycle. Must equal the operand width.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: upstream presents an operation.
- `in_ready`, output, 1: the stage can accept an operation this cycle.
- `opcode`, input, 4: operation select.
- `op_a`, input, 64: operand A.
- `op_b`, input, 64: operand B.
- `imm`, input, 8: address offset for LOAD and STORE.
- `out_valid`, output, 1: the result bundle is valid.
- `out_ready`, input, 1: memory access consumes the bundle.
- `Address_and_Value`, output, 72: bits [71:8] are the value and bits [7:0] are the address.
- `isLoad`, output, 1: the bundle is a load.
- `isMemWrite`, output, 1: the bundle is a store.
- `busy`, output, 1: a multiply is in progress.

## Operation
- Acceptance occurs on a rising edge where `in_valid && in_ready`. `in_ready = !rst && state==IDLE && (!out_valid || out_ready)`.
- The FSM has three states: IDLE, MUL, and DONE.
  - In IDLE, accepting a non-MUL operation writes the output registers and sets `out_valid`; the FSM stays in IDLE.
  - In IDLE, accepting MUL latches `op_a`/`op_b`, clears the accumulator and counter, goes to MUL, and sets `busy=1`.
  - MUL performs one shift-add step per edge: if `b[0]`, `acc += a`; then `a <<= 1` and `b >>= 1`. After `MUL_CYCLES` steps it writes the output, sets `out_valid`, clears `busy`, and goes to DONE.
  - DONE returns to IDLE on the next edge.
- Opcodes (address is `(op_a[7:0] + imm)` mod 256 for LOAD and STORE, and 0 otherwise):
  - 0 ADD: value = `op_a+op_b` mod 2^64.
  - 1 SUB: value = `op_a-op_b` mod 2^64.
  - 2 AND, 3 OR, 4 XOR: bitwise on `op_a` and `op_b`.
  - 5 SLL and 6 SRL: shift `op_a` left or right (logical) by `op_b[5:0]`.
  - 7 SLT: value = 1 if `op_a < op_b` signed, else 0.
  - 8 MUL: value = low 64 bits of `op_a*op_b`.
  - 9 LOAD: value 0, `isLoad=1`.
  - 10 STORE: value `op_b`, `isMemWrite=1`.
  - 11–15 NOP: value 0, address 0, both flags 0; still produces `out_valid`.
- `isLoad` and `isMemWrite` are never both 1.
- Output slot behaviour:
  - When `out_valid && !out_ready`, all outputs hold stable.
  - On `out_valid && out_ready` with no new result, `out_valid` clears.
  - On `out_valid && out_ready` with a simultaneous accept or multiply completion, the new result replaces the old and `out_valid` stays 1.
- Multiply completion with `out_valid && !out_ready` cannot occur, because MUL is only accepted when the slot will be free and no other acceptance happens during MUL.

## Timing
- Reset values: `out_valid=0`, `Address_and_Value=0`, `isLoad=0`, `isMemWrite=0`, `busy=0`, state IDLE, counter 0; `in_ready=0` while `rst=1`.
- Non-MUL latency is 1: accept at edge N, and `out_valid=1` in the cycle after edge N.
- MUL latency is `MUL_CYCLES+1`:
  - Accept at edge N; `busy=1` after edge N.
  - `out_valid=1` and `busy=0` after edge N+64.
  - `in_ready=0` from after edge N until after edge N+65 (the DONE cycle).
- Throughput is one non-MUL operation per cycle when `out_ready=1`.
- Reset asserted mid-multiply aborts the operation: the result is discarded and all reset values apply on the next edge.
- Inputs are sampled only at acceptance; the operands are latched for MUL.

## Test plan
- ADD: `op_a=5`, `op_b=7`, `out_ready=1` → one cycle later `out_valid=1`, `Address_and_Value=72'h0000000000000000C_00`, `isLoad=0`, `isMemWrite=0`.
- STORE wrap: `op_a=8'hFE`, `imm=8'h03`, `op_b=64'h1234` → address `8'h01`, value `64'h1234`, `isMemWrite=1`; LOAD with the same operands → address `8'h01`, value 0, `isLoad=1`.
- MUL: `op_a=64'hFFFF_FFFF_FFFF_FFFF`, `op_b=3` → `busy` for 64 cycles, `in_ready=0` for 65 cycles, then value `64'hFFFF_FFFF_FFFF_FFFD`.
- Backpressure: SUB `10-3` with `out_ready=0` for 5 cycles → outputs hold value 7 and `in_ready=0`; raise `out_ready` with a queued XOR → back-to-back handover with no bubble.
- Reset mid-MUL: assert `rst` 20 cycles after MUL is accepted → the next cycle shows `busy=0` and `out_valid=0`; a fresh ADD then completes normally.
- SLT/shift edge cases:
  - SLT `op_a=-1`, `op_b=0` → 1.
  - SLL `op_a=1`, `op_b=64'h41` → shift by 1 → 2.
  - Opcode 15 → all-zero bundle with `out_valid=1`.
